// File: rtl/led_blink_pkg.sv
// rtl/led_blink_pkg.sv - mode encoding shared by the multi-channel LED blinker
package led_blink_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_OFF     = 2'b00;
    localparam mode_t MODE_ON      = 2'b01;
    localparam mode_t MODE_BLINK   = 2'b10;
    localparam mode_t MODE_ONESHOT = 2'b11;

endpackage

// File: rtl/led_channel.sv
// rtl/led_channel.sv - one LED channel: mode/half registers, tick counter, LED flop
module led_channel
    import led_blink_pkg::*;
#(
    parameter int PW       = 10,
    parameter int DEF_HALF = 500
) (
    input  logic          CLOCK_50,
    input  logic          KEY0,
    input  logic          tick,
    input  logic          wr,
    input  mode_t         mode,
    input  logic [PW-1:0] half,
    output logic          led,
    output logic          done
);

    mode_t         mode_q;
    logic [PW-1:0] half_q;
    logic [PW-1:0] cnt;
    logic [PW-1:0] last_cnt;
    logic          running;

    // A stored half of zero behaves as one, so the last count is 0 in both cases.
    assign last_cnt = (half_q == '0) ? '0 : half_q - PW'(1);
    assign running  = (mode_q == MODE_BLINK) || (mode_q == MODE_ONESHOT);

    always_ff @(posedge CLOCK_50) begin
        if (!KEY0) begin
            mode_q <= MODE_OFF;
            half_q <= PW'(DEF_HALF);
            cnt    <= '0;
            led    <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (wr) begin
                // A write takes priority over a coincident tick.
                mode_q <= mode;
                half_q <= half;
                cnt    <= '0;
                led    <= (mode != MODE_OFF);
            end else if (running && tick) begin
                if (cnt == last_cnt) begin
                    cnt <= '0;
                    if (mode_q == MODE_BLINK) begin
                        led <= ~led;
                    end else begin
                        led    <= 1'b0;
                        mode_q <= MODE_OFF;
                        done   <= 1'b1;
                    end
                end else begin
                    cnt <= cnt + PW'(1);
                end
            end else if (!running) begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/led_blink_multi.sv
// rtl/led_blink_multi.sv - shared prescaler, write decode and N LED channels
module led_blink_multi
    import led_blink_pkg::*;
#(
    parameter int  N_CH     = 8,
    parameter int  TICK_DIV = 50000,
    parameter int  PW       = 10,
    parameter int  DEF_HALF = 500,
    localparam int CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic            CLOCK_50,
    input  logic            KEY0,
    input  logic            cfg_we,
    input  logic [CH_W-1:0] cfg_ch,
    input  mode_t           cfg_mode,
    input  logic [PW-1:0]   cfg_half,
    output logic [N_CH-1:0] LEDG,
    output logic [N_CH-1:0] done,
    output logic            tick
);

    localparam int PS_W = $clog2(TICK_DIV);

    logic [PS_W-1:0] psc;
    logic            psc_last;
    logic [N_CH-1:0] wr;

    assign psc_last = (psc == PS_W'(TICK_DIV - 1));

    // Free-running: configuration writes never disturb the tick phase.
    always_ff @(posedge CLOCK_50) begin
        if (!KEY0) begin
            psc  <= '0;
            tick <= 1'b0;
        end else begin
            psc  <= psc_last ? '0 : psc + PS_W'(1);
            tick <= psc_last;
        end
    end

    // Channel indices at or beyond N_CH match no channel and are dropped.
    always_comb begin
        wr = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (cfg_we && (int'(cfg_ch) == i)) begin
                wr[i] = 1'b1;
            end
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        led_channel #(
            .PW       (PW),
            .DEF_HALF (DEF_HALF)
        ) u_ch (
            .CLOCK_50 (CLOCK_50),
            .KEY0     (KEY0),
            .tick     (tick),
            .wr       (wr[g]),
            .mode     (cfg_mode),
            .half     (cfg_half),
            .led      (LEDG[g]),
            .done     (done[g])
        );
    end

endmodule

// File: tb/tb_led_blink_multi.sv
// tb/tb_led_blink_multi.sv - directed self-checking bench for led_blink_multi
module tb_led_blink_multi;
    import led_blink_pkg::*;

    logic       CLOCK_50 = 1'b0;
    logic       KEY0     = 1'b0;
    logic       cfg_we   = 1'b0;
    logic [1:0] cfg_ch   = '0;
    mode_t      cfg_mode = MODE_OFF;
    logic [3:0] cfg_half = '0;
    logic [3:0] LEDG;
    logic [3:0] done;
    logic       tick;
    logic [2:0] LEDG3;
    logic [2:0] done3;
    logic       tick3;

    int total = 0;
    int bad   = 0;

    led_blink_multi #(.N_CH(4), .TICK_DIV(4), .PW(4), .DEF_HALF(2)) u_dut (
        .CLOCK_50 (CLOCK_50), .KEY0 (KEY0), .cfg_we (cfg_we), .cfg_ch (cfg_ch),
        .cfg_mode (cfg_mode), .cfg_half (cfg_half),
        .LEDG (LEDG), .done (done), .tick (tick)
    );

    // Three-channel copy: same 2-bit cfg_ch, so cfg_ch = 3 is out of range here.
    led_blink_multi #(.N_CH(3), .TICK_DIV(4), .PW(4), .DEF_HALF(2)) u_dut3 (
        .CLOCK_50 (CLOCK_50), .KEY0 (KEY0), .cfg_we (cfg_we), .cfg_ch (cfg_ch),
        .cfg_mode (cfg_mode), .cfg_half (cfg_half),
        .LEDG (LEDG3), .done (done3), .tick (tick3)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic wr_cfg(input logic [1:0] ch, input mode_t m, input logic [3:0] h);
        cfg_we   = 1'b1;
        cfg_ch   = ch;
        cfg_mode = m;
        cfg_half = h;
        step();
        cfg_we   = 1'b0;
    endtask

    task automatic wait_led(input int ch, input logic val, input int lim, output int n);
        n = 0;
        while (LEDG[ch] !== val && n < lim) begin
            step();
            n++;
        end
    endtask

    task automatic count_act(input int ch, input int cycles, output int nd, output int nl);
        nd = 0;
        nl = 0;
        for (int k = 0; k < cycles; k++) begin
            step();
            nd += int'(done[ch]);
            nl += int'(LEDG[ch]);
        end
    endtask

    initial begin
        int n;
        int nd;
        int nl;

        // Reset held with a write pending: everything stays cleared.
        cfg_we   = 1'b1;
        cfg_ch   = 2'd1;
        cfg_mode = MODE_BLINK;
        cfg_half = 4'd3;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("reset_outs", {LEDG, done, tick}, 9'd0);
        end
        KEY0   = 1'b1;
        cfg_we = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            step();
            chk("tick_phase", tick, (k % 4) == 0);
        end

        // BLINK ch1, half 3: first interval 9..12 cycles, then exactly 12.
        wr_cfg(2'd1, MODE_BLINK, 4'd3);
        chk("blink_on", LEDG, 4'b0010);
        wait_led(1, 1'b0, 20, n);
        chk("blink_first", (n >= 9 && n <= 12), 1);
        wait_led(1, 1'b1, 20, n);
        chk("blink_per_a", n, 12);
        chk("blink_others", LEDG & 4'b1101, 0);
        wait_led(1, 1'b0, 20, n);
        chk("blink_per_b", n, 12);
        chk("blink_others2", LEDG & 4'b1101, 0);

        // ONESHOT ch2, half 2: on for 5..8 cycles, done coincides with the fall.
        wr_cfg(2'd2, MODE_ONESHOT, 4'd2);
        chk("os_on", LEDG[2], 1);
        n  = 0;
        nd = 0;
        while (LEDG[2] === 1'b1 && n < 12) begin
            step();
            n++;
            nd += int'(done[2]);
        end
        chk("os_len", (n >= 5 && n <= 8), 1);
        chk("os_done_fall", done[2], 1);
        chk("os_done_once", nd, 1);
        count_act(2, 20, nd, nl);
        chk("os_quiet", nd + nl, 0);

        // Half 0 behaves as half 1: toggle on every tick.
        wr_cfg(2'd0, MODE_BLINK, 4'd0);
        chk("h0_on", LEDG[0], 1);
        wait_led(0, 1'b0, 8, n);
        chk("h0_first", (n >= 1 && n <= 4), 1);
        wait_led(0, 1'b1, 8, n);
        chk("h0_per_a", n, 4);
        wait_led(0, 1'b0, 8, n);
        chk("h0_per_b", n, 4);

        // Quiesce, then write channel 3: out of range for the 3-channel copy.
        wr_cfg(2'd0, MODE_OFF, 4'd2);
        wr_cfg(2'd1, MODE_OFF, 4'd2);
        chk("quiet_all", {LEDG, LEDG3}, 7'd0);
        wr_cfg(2'd3, MODE_ON, 4'd2);
        chk("inv_ch_main", LEDG, 4'b1000);
        chk("inv_ch_n3", LEDG3, 3'b000);
        step();
        step();
        chk("inv_ch_n3_hold", LEDG3, 3'b000);

        // Write on ch3 exactly on a tick edge: tick ignored, toggle 8 cycles later.
        n = 0;
        while (tick !== 1'b1 && n < 8) begin
            step();
            n++;
        end
        chk("tick_found", tick, 1);
        wr_cfg(2'd3, MODE_BLINK, 4'd2);
        chk("coll_led", LEDG[3], 1);
        wait_led(3, 1'b0, 16, n);
        chk("coll_per", n, 8);
        wr_cfg(2'd3, MODE_OFF, 4'd2);

        // Re-written ONESHOT restarts; a single done pulse overall.
        wr_cfg(2'd2, MODE_ONESHOT, 4'd2);
        count_act(2, 3, nd, nl);
        chk("abort_early", {nd[3:0], nl[3:0]}, {4'd0, 4'd3});
        wr_cfg(2'd2, MODE_ONESHOT, 4'd2);
        n = 0;
        while (LEDG[2] === 1'b1 && n < 12) begin
            step();
            n++;
            nd += int'(done[2]);
        end
        chk("abort_len", (n >= 5 && n <= 8), 1);
        count_act(2, 20, nl, n);
        chk("abort_one_done", nd + nl, 1);

        // Reset during a long ONESHOT: LED cleared, no done pulse.
        wr_cfg(2'd2, MODE_ONESHOT, 4'd4);
        step();
        step();
        chk("rst_pre", LEDG[2], 1);
        KEY0 = 1'b0;
        step();
        chk("rst_mid", {LEDG, done, tick}, 9'd0);
        KEY0 = 1'b1;
        count_act(2, 25, nd, nl);
        chk("rst_after", nd + nl, 0);
        chk("rst_all_off", LEDG, 4'b0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
